mmio_uart_responder: RTL and testbench

Memory-mapped I/O responder on the processor's memory bus (address / read / writeData / writeMask / readData), sitting beside program_memory in the SOC. Decodes a fixed I/O window and serves four word registers: an LED latch, a UART transmit data port, a UART status word and a free-running cycle counter. Drives a serial 8N1 TXD line from an internal transmit state machine. The SOC muxes readData between this block and program_memory using the registered `hit` output.

---
 rtl/mmio_uart_responder.sv | 168 ++++++++++++++++
 tb/tb_mmio_uart_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_responder.sv
// rtl/mmio_uart_responder.sv - memory-mapped LED latch, UART transmitter and cycle counter
module mmio_uart_responder #(
    parameter logic [31:0] IO_BASE      = 32'h0040_0000,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] address,
    input  logic        read,
    input  logic [31:0] writeData,
    input  logic [3:0]  writeMask,
    output logic [31:0] readData,
    output logic        hit,
    output logic [31:0] LEDS,
    output logic        TXD
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [31:0]       leds_q, leds_d;
    logic [7:0]        last_byte_q, last_byte_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              hit_q, hit_d;

    logic        sel;
    logic [9:0]  offset;
    logic        busy;
    logic        baud_done;
    logic        uart_wr;
    logic        accept;
    logic        txd;
    logic [31:0] reg_value;

    assign sel       = (address[31:12] == IO_BASE[31:12]);
    assign offset    = address[11:2];
    assign busy      = (state_q != ST_IDLE);
    assign baud_done = (baud_q == BAUD_LAST);
    assign uart_wr   = sel && (offset == 10'd1) && writeMask[0];
    // The transmitter can take a new byte on the very edge that ends the stop bit.
    assign accept    = uart_wr && (!busy || (state_q == ST_STOP && baud_done));

    assign readData = read_data_q;
    assign hit      = hit_q;
    assign LEDS     = leds_q;
    assign TXD      = txd;

    // Register read mux; values are pre-write so a same-cycle read sees the old contents.
    always_comb begin
        reg_value = 32'd0;
        case (offset)
            10'd0:   reg_value = leds_q;
            10'd1:   reg_value = {24'd0, last_byte_q};
            10'd2:   reg_value = {29'd0, overflow_q, !busy, busy};
            10'd3:   reg_value = cycle_q;
            default: reg_value = 32'd0;
        endcase
    end

    // Bus-side register updates: reads, LED byte lanes, last byte, sticky overflow, counter.
    always_comb begin
        read_data_d = read_data_q;
        hit_d       = hit_q;
        leds_d      = leds_q;
        last_byte_d = last_byte_q;
        overflow_d  = overflow_q;
        cycle_d     = cycle_q + 32'd1;
        if (read) begin
            hit_d = sel;
            if (sel) begin
                read_data_d = reg_value;
            end
        end
        if (sel && offset == 10'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (writeMask[i]) begin
                    leds_d[8*i +: 8] = writeData[8*i +: 8];
                end
            end
        end
        if (sel && offset == 10'd2 && writeMask[0] && writeData[2]) begin
            overflow_d = 1'b0;
        end
        if (accept) begin
            last_byte_d = writeData[7:0];
        end else if (uart_wr) begin
            overflow_d = 1'b1;
        end
    end

    // Transmit FSM next state and serial line value.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_done ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
            end
            ST_START: begin
                txd = 1'b0;
                if (baud_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                txd = shift_q[0];
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_START;
            shift_d = writeData[7:0];
            bit_d   = 3'd0;
            baud_d  = '0;
        end
    end

    // State registers; reset drops the line to idle immediately and aborts any frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            leds_q      <= 32'd0;
            last_byte_q <= 8'd0;
            overflow_q  <= 1'b0;
            cycle_q     <= 32'd0;
            read_data_q <= 32'd0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            leds_q      <= leds_d;
            last_byte_q <= last_byte_d;
            overflow_q  <= overflow_d;
            cycle_q     <= cycle_d;
            read_data_q <= read_data_d;
            hit_q       <= hit_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// tb/tb_mmio_uart_responder.sv - scoreboard bench for mmio_uart_responder
module tb_mmio_uart_responder;

    localparam logic [31:0] IO_BASE = 32'h0040_0000;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] address;
    logic        read;
    logic [31:0] writeData;
    logic [3:0]  writeMask;
    logic [31:0] readData;
    logic        hit;
    logic [31:0] LEDS;
    logic        TXD;

    mmio_uart_responder #(.IO_BASE(IO_BASE), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RESET(RESET), .address(address), .read(read),
        .writeData(writeData), .writeMask(writeMask), .readData(readData),
        .hit(hit), .LEDS(LEDS), .TXD(TXD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic [31:0] leds;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    int checks = 0;
    int errors = 0;
    int reset_gen = 0;
    int tx_falls = 0;

    // Reference model: register contents plus frame timing expressed in edge numbers.
    logic [31:0] m_leds, m_rd;
    logic        m_hit, m_ovf;
    logic [7:0]  m_last;
    int          m_k, m_a;
    bit          m_have;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_leds = 0; m_rd = 0; m_hit = 0; m_ovf = 0; m_last = 0;
        m_k = 0; m_a = 0; m_have = 0;
        tx_q.delete();
    endtask

    // One bus cycle: inputs applied at a negedge, model advanced for the following posedge.
    task automatic bus(input logic [31:0] addr, input logic rd, input logic [31:0] wd, input logic [3:0] m);
        logic        s;
        logic [9:0]  off;
        int          d;
        bit          busy, free;
        logic [31:0] val;
        rd_exp_t     e;
        @(negedge CLK);
        address = addr; read = rd; writeData = wd; writeMask = m;
        s    = (addr[31:12] == IO_BASE[31:12]);
        off  = addr[11:2];
        m_k++;
        d    = m_have ? (m_k - m_a) : 1000;
        busy = m_have && d >= 1 && d <= FRAME;
        free = !m_have || d >= FRAME;
        case (off)
            10'd0:   val = m_leds;
            10'd1:   val = {24'd0, m_last};
            10'd2:   val = {29'd0, m_ovf, !busy, busy};
            10'd3:   val = m_k - 1;
            default: val = 0;
        endcase
        if (rd) begin
            m_hit = s;
            if (s) m_rd = val;
        end
        if (s && m != 4'd0) begin
            if (off == 10'd0) begin
                for (int i = 0; i < 4; i++)
                    if (m[i]) m_leds[8*i +: 8] = wd[8*i +: 8];
            end else if (off == 10'd1 && m[0]) begin
                if (free) begin
                    m_last = wd[7:0]; m_a = m_k; m_have = 1; tx_q.push_back(wd[7:0]);
                end else begin
                    m_ovf = 1;
                end
            end else if (off == 10'd2 && m[0] && wd[2]) begin
                m_ovf = 0;
            end
        end
        if (rd) begin
            e.data = m_rd; e.hit = m_hit; e.leds = m_leds;
            rd_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(32'd0, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic do_reset(input bit check);
        @(negedge CLK);
        RESET = 1'b1; read = 0; writeMask = 0; address = 0; writeData = 0;
        reset_gen++;
        #1;
        if (check) begin
            chk("rst_txd", {31'd0, TXD}, 32'd1);
            chk("rst_leds", LEDS, 32'd0);
            chk("rst_readdata", readData, 32'd0);
            chk("rst_hit", {31'd0, hit}, 32'd0);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        m_k = 1;
    endtask

    // Read monitor: one expected response per read edge.
    always @(posedge CLK) begin
        #1;
        if (rd_q.size() > 0) begin
            rd_exp_t e;
            e = rd_q.pop_front();
            chk("rd_data", readData, e.data);
            chk("rd_hit", {31'd0, hit}, {31'd0, e.hit});
            chk("leds", LEDS, e.leds);
        end
    end

    always @(negedge TXD) tx_falls++;

    // Serial receiver: samples the middle of every bit of each frame.
    initial begin
        forever begin
            int         g;
            bit         aborted;
            logic       start_b, stop_b;
            logic [7:0] b;
            @(negedge TXD);
            g = reset_gen;
            aborted = 0;
            b = 8'd0;
            repeat (CPB / 2) @(posedge CLK);
            #1;
            start_b = TXD;
            if (g != reset_gen) aborted = 1;
            for (int i = 0; i < 8; i++) begin
                if (!aborted) begin
                    repeat (CPB) @(posedge CLK);
                    #1;
                    b[i] = TXD;
                    if (g != reset_gen) aborted = 1;
                end
            end
            stop_b = 1'b1;
            if (!aborted) begin
                repeat (CPB) @(posedge CLK);
                #1;
                stop_b = TXD;
                if (g != reset_gen) aborted = 1;
            end
            if (!aborted) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected actual=%h expected=none", b);
                end else begin
                    chk("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                end
                chk("tx_start", {31'd0, start_b}, 32'd0);
                chk("tx_stop", {31'd0, stop_b}, 32'd1);
            end
        end
    end

    initial begin
        int falls0;
        logic [31:0] a;
        RESET = 1'b1; address = 0; read = 0; writeData = 0; writeMask = 0;
        do_reset(1'b1);

        // LED byte lanes and readback
        bus(IO_BASE, 0, 32'hAABBCCDD, 4'b1111);
        bus(IO_BASE, 0, 32'h00000011, 4'b0001);
        bus(IO_BASE, 1, 32'd0, 4'd0);
        idle(1);
        chk("leds_direct", LEDS, 32'hAABBCC11);
        chk("leds_readback", readData, 32'hAABBCC11);

        // UART frame 0xA5 with status polled throughout
        bus(IO_BASE + 4, 0, 32'hA5, 4'b0001);
        for (int i = 0; i < FRAME + 4; i++) bus(IO_BASE + 8, 1, 32'd0, 4'd0);

        // Overflow
        bus(IO_BASE + 4, 0, 32'h55, 4'b0001);
        bus(IO_BASE + 4, 0, 32'h33, 4'b0001);
        bus(IO_BASE + 4, 1, 32'd0, 4'd0);
        bus(IO_BASE + 8, 1, 32'd0, 4'd0);
        idle(1);
        chk("ovf_status", readData, 32'h5);
        bus(IO_BASE + 8, 0, 32'h4, 4'b0001);
        bus(IO_BASE + 8, 1, 32'd0, 4'd0);
        idle(FRAME);

        // Decode
        bus(IO_BASE + 32'h10, 1, 32'd0, 4'd0);
        bus(32'd400, 1, 32'd0, 4'd0);
        bus(32'd400, 0, 32'hFFFFFFFF, 4'b1111);
        bus(IO_BASE, 1, 32'd0, 4'd0);

        // Cycle counter
        bus(IO_BASE + 12, 1, 32'd0, 4'd0);
        idle(7);
        bus(IO_BASE + 12, 1, 32'd0, 4'd0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            a = IO_BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            case (r)
                0, 1: bus(a, 1, $urandom, 4'd0);
                2: begin
                    a = $urandom;
                    if (a[31:12] == IO_BASE[31:12]) a[31] = ~a[31];
                    bus(a, $urandom_range(0, 1), $urandom, 4'($urandom));
                end
                3: bus(IO_BASE, $urandom_range(0, 1), $urandom, 4'($urandom));
                4: bus(IO_BASE + 4, $urandom_range(0, 1), $urandom, 4'($urandom));
                5: bus(IO_BASE + 8, $urandom_range(0, 1), $urandom, 4'($urandom));
                6: bus(a, 1, $urandom, 4'($urandom));
                default: idle(1);
            endcase
        end
        idle(FRAME + 4);

        // Reset in the middle of a frame
        bus(IO_BASE + 4, 0, 32'hC3, 4'b0001);
        idle(10);
        do_reset(1'b1);
        falls0 = tx_falls;
        idle(60);
        chk("no_residual_tx", tx_falls, falls0);
        bus(IO_BASE + 8, 1, 32'd0, 4'd0);
        idle(1);
        chk("status_after_reset", readData, 32'h2);
        idle(4);

        chk("tx_queue_drained", tx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
